action_engine_pipe: RTL

ACTION_ENGINE_PIPE -- requirements
Module: action_engine_pipe

---
 rtl/action_engine_pkg.sv | 29 ++
 rtl/action_alu_lane.sv | 44 ++++
 rtl/action_engine_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/action_engine_pkg.sv
// Shared opcode constants and action-word field offsets for the action engine.
// Field layout per lane, MSB to LSB: {op[3:0], src1[IDX_W], src2[IDX_W], imm[IMM_W]}.
package action_engine_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_SUBI = 4'd4;
   localparam logic [3:0] OP_SET  = 4'd5;
   localparam logic [3:0] OP_COPY = 4'd6;

   function automatic int act_width(input int idx_w, input int imm_w);
      return 4 + 2 * idx_w + imm_w;
   endfunction

   function automatic int act_op_lsb(input int idx_w, input int imm_w);
      return imm_w + 2 * idx_w;
   endfunction

   function automatic int act_src1_lsb(input int idx_w, input int imm_w);
      return imm_w + idx_w;
   endfunction

   function automatic int act_src2_lsb(input int imm_w);
      return imm_w;
   endfunction

endpackage

// File: rtl/action_alu_lane.sv
// One container lane: combinational op decode feeding the stage-2 result register.
module action_alu_lane
   import action_engine_pkg::*;
#(
   parameter int CONT_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [3:0]        op,
   input  logic [CONT_W-1:0] a,
   input  logic [CONT_W-1:0] b,
   input  logic [CONT_W-1:0] orig,
   input  logic [IMM_W-1:0]  imm,
   output logic [CONT_W-1:0] result
);

   logic [CONT_W-1:0] imm_ext;
   logic [CONT_W-1:0] next_result;

   // The size cast zero-extends a narrow immediate and truncates a wide one.
   assign imm_ext = CONT_W'(imm);

   always_comb begin
      next_result = orig;
      case (op)
         OP_NOP:  next_result = orig;
         OP_ADD:  next_result = a + b;
         OP_SUB:  next_result = a - b;
         OP_ADDI: next_result = a + imm_ext;
         OP_SUBI: next_result = a - imm_ext;
         OP_SET:  next_result = imm_ext;
         OP_COPY: next_result = a;
         default: next_result = orig;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) result <= '0;
      else if (load) result <= next_result;
   end

endmodule

// File: rtl/action_engine_pipe.sv
// Two-stage PHV action engine: S1 registers operands, S2 registers lane results.
// Optional statistics counters are enabled by defining ACTION_ENGINE_PIPE_STATS_EN.
module action_engine_pipe
   import action_engine_pkg::*;
#(
   parameter int  NUM_CONT = 16,
   parameter int  CONT_W   = 32,
   parameter int  META_W   = 356,
   parameter int  IMM_W    = 16,
   localparam int IDX_W    = $clog2(NUM_CONT),
   localparam int ACT_W    = act_width(IDX_W, IMM_W),
   localparam int PHV_W    = NUM_CONT * CONT_W + META_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PHV_W-1:0]          phv_in,
   input  logic                      phv_in_valid,
   output logic                      phv_in_ready,
   input  logic [NUM_CONT*ACT_W-1:0] action_in,
   output logic [PHV_W-1:0]          phv_out,
   output logic                      phv_out_valid,
   input  logic                      phv_out_ready
`ifdef ACTION_ENGINE_PIPE_STATS_EN
   ,
   output logic [31:0]               stat_phv_cnt,
   output logic [31:0]               stat_stall_cnt
`endif
);

   localparam int OP_LSB   = act_op_lsb(IDX_W, IMM_W);
   localparam int SRC1_LSB = act_src1_lsb(IDX_W, IMM_W);
   localparam int SRC2_LSB = act_src2_lsb(IMM_W);

   logic              s1_valid;
   logic              s2_valid;
   logic              s2_adv;
   logic              s2_load;
   logic              in_fire;
   logic [META_W-1:0] s1_meta;
   logic [META_W-1:0] s2_meta;
   logic [CONT_W-1:0] cont_in     [NUM_CONT];
   logic [CONT_W-1:0] lane_result [NUM_CONT];

   // S2 can take new data when empty or when its PHV leaves this cycle.
   assign s2_adv        = !s2_valid || phv_out_ready;
   assign s2_load       = s1_valid && s2_adv;
   assign phv_in_ready  = !s1_valid || s2_adv;
   assign in_fire       = phv_in_valid && phv_in_ready;
   assign phv_out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_meta  <= '0;
      end else begin
         if (phv_in_ready) s1_valid <= phv_in_valid;
         if (s2_adv) s2_valid <= s1_valid;
         if (s2_load) s2_meta <= s1_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) s1_meta <= phv_in[META_W-1:0];
   end

   for (genvar k = 0; k < NUM_CONT; k++) begin : g_lane
      logic [3:0]        f_op;
      logic [IDX_W-1:0]  f_src1;
      logic [IDX_W-1:0]  f_src2;
      logic [IMM_W-1:0]  f_imm;
      logic [CONT_W-1:0] sel_a;
      logic [CONT_W-1:0] sel_b;
      logic [CONT_W-1:0] s1_a;
      logic [CONT_W-1:0] s1_b;
      logic [CONT_W-1:0] s1_orig;
      logic [3:0]        s1_op;
      logic [IMM_W-1:0]  s1_imm;

      assign cont_in[k] = phv_in[META_W + k*CONT_W +: CONT_W];
      assign f_op       = action_in[k*ACT_W + OP_LSB +: 4];
      assign f_src1     = action_in[k*ACT_W + SRC1_LSB +: IDX_W];
      assign f_src2     = action_in[k*ACT_W + SRC2_LSB +: IDX_W];
      assign f_imm      = action_in[k*ACT_W +: IMM_W];

      // Indices with no matching container fall through to an operand of zero.
      always_comb begin
         sel_a = '0;
         sel_b = '0;
         for (int j = 0; j < NUM_CONT; j++) begin
            if (f_src1 == IDX_W'(j)) sel_a = cont_in[j];
            if (f_src2 == IDX_W'(j)) sel_b = cont_in[j];
         end
      end

      always_ff @(posedge clk) begin
         if (in_fire) begin
            s1_a    <= sel_a;
            s1_b    <= sel_b;
            s1_orig <= cont_in[k];
            s1_op   <= f_op;
            s1_imm  <= f_imm;
         end
      end

      action_alu_lane #(
         .CONT_W(CONT_W),
         .IMM_W (IMM_W)
      ) u_alu (
         .clk   (clk),
         .rst   (rst),
         .load  (s2_load),
         .op    (s1_op),
         .a     (s1_a),
         .b     (s1_b),
         .orig  (s1_orig),
         .imm   (s1_imm),
         .result(lane_result[k])
      );
   end

   always_comb begin
      phv_out               = '0;
      phv_out[META_W-1:0]   = s2_meta;
      for (int k = 0; k < NUM_CONT; k++) begin
         phv_out[META_W + k*CONT_W +: CONT_W] = lane_result[k];
      end
   end

`ifdef ACTION_ENGINE_PIPE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_phv_cnt   <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (phv_out_valid && phv_out_ready) stat_phv_cnt <= stat_phv_cnt + 32'd1;
         if (phv_out_valid && !phv_out_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
